// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Fetches a byte-coded program from an external memory over a request/ack
// handshake and drives an external combinational ALU from its own registers.
//
// Instruction byte: class = ir[7:4], aluop = ir[3:0]
//   class 0  ALU imm : opnd = imm, then one EXEC cycle latches the ALU result
//   class 1  LDI imm : acc = imm, zero_flag = (imm == 0), carry unchanged
//   class 2  HALT
//   class 3  JZ  imm : pc = imm when zero_flag is set
//   class 4  CLC     : carry_flag = 0
//   class 5-15       : one-byte NOP
//
// Ports
//   clk, reset       clock, asynchronous active-high reset
//   start            run from address 0 (honoured only in IDLE or HALT)
//   mem_addr/mem_rd  program memory request, held stable until mem_ack
//   mem_ack/mem_data read completion and returned byte
//   alu_a/alu_b/alu_carry/alu_op   ALU operands (acc, opnd, carry_flag, ir[3:0])
//   alu_c/alu_carry_out/alu_zero   ALU result and flags
//   acc, carry_flag, zero_flag     architectural state
//   busy             high in FETCH, OPERAND, EXEC
//   halted           high in HALT
// -----------------------------------------------------------------------------
module alu_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [7:0] mem_addr,
    output logic       mem_rd,
    input  logic       mem_ack,
    input  logic [7:0] mem_data,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_carry,
    output logic [3:0] alu_op,
    input  logic [7:0] alu_c,
    input  logic       alu_carry_out,
    input  logic       alu_zero,
    output logic [7:0] acc,
    output logic       carry_flag,
    output logic       zero_flag,
    output logic       busy,
    output logic       halted
);

    localparam logic [3:0] CLS_ALU  = 4'd0;
    localparam logic [3:0] CLS_LDI  = 4'd1;
    localparam logic [3:0] CLS_HALT = 4'd2;
    localparam logic [3:0] CLS_JZ   = 4'd3;
    localparam logic [3:0] CLS_CLC  = 4'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_OPERAND,
        S_EXEC,
        S_HALT
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] pc;
    logic [7:0] ir;
    logic [7:0] opnd;
    logic [7:0] pc_inc;
    logic       rd_done;

    assign pc_inc  = pc + 8'd1;
    // An ack only counts while a request is outstanding; mem_rd is only ever
    // high in FETCH/OPERAND, so stray acks elsewhere are ignored.
    assign rd_done = mem_rd & mem_ack;

    assign alu_a     = acc;
    assign alu_b     = opnd;
    assign alu_carry = carry_flag;
    assign alu_op    = ir[3:0];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (rd_done) begin
                    case (mem_data[7:4])
                        CLS_ALU, CLS_LDI, CLS_JZ: state_next = S_OPERAND;
                        CLS_HALT:                 state_next = S_HALT;
                        default:                  state_next = S_FETCH;
                    endcase
                end
            end
            S_OPERAND: begin
                if (rd_done) begin
                    if (ir[7:4] == CLS_LDI || ir[7:4] == CLS_JZ) state_next = S_FETCH;
                    else                                         state_next = S_EXEC;
                end
            end
            S_EXEC:  state_next = S_FETCH;
            default: state_next = S_IDLE;
        endcase
    end

    // Status outputs
    always_comb begin
        busy   = 1'b0;
        halted = 1'b0;
        case (state)
            S_FETCH, S_OPERAND, S_EXEC: busy   = 1'b1;
            S_HALT:                     halted = 1'b1;
            default: ;
        endcase
    end

    // Datapath and memory handshake.
    // Each read state spends one cycle with mem_rd low before raising it, so
    // mem_rd always drops for a cycle after an ack. mem_addr is loaded with the
    // next fetch address on every transition into a read state and otherwise
    // keeps the last address read (so HALT shows where the HALT byte was).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= 8'd0;
            ir         <= 8'd0;
            opnd       <= 8'd0;
            acc        <= 8'd0;
            carry_flag <= 1'b0;
            zero_flag  <= 1'b0;
            mem_rd     <= 1'b0;
            mem_addr   <= 8'd0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        pc       <= 8'd0;
                        mem_addr <= 8'd0;
                    end
                end
                S_FETCH: begin
                    if (!mem_rd) begin
                        mem_rd <= 1'b1;
                    end else if (mem_ack) begin
                        mem_rd <= 1'b0;
                        ir     <= mem_data;
                        pc     <= pc_inc;
                        if (mem_data[7:4] != CLS_HALT) mem_addr <= pc_inc;
                        if (mem_data[7:4] == CLS_CLC) carry_flag <= 1'b0;
                    end
                end
                S_OPERAND: begin
                    if (!mem_rd) begin
                        mem_rd <= 1'b1;
                    end else if (mem_ack) begin
                        mem_rd <= 1'b0;
                        case (ir[7:4])
                            CLS_LDI: begin
                                acc       <= mem_data;
                                zero_flag <= (mem_data == 8'd0);
                                pc        <= pc_inc;
                                mem_addr  <= pc_inc;
                            end
                            CLS_JZ: begin
                                if (zero_flag) begin
                                    pc       <= mem_data;
                                    mem_addr <= mem_data;
                                end else begin
                                    pc       <= pc_inc;
                                    mem_addr <= pc_inc;
                                end
                            end
                            default: begin
                                opnd <= mem_data;
                                pc   <= pc_inc;
                            end
                        endcase
                    end
                end
                S_EXEC: begin
                    acc        <= alu_c;
                    carry_flag <= alu_carry_out;
                    zero_flag  <= alu_zero;
                    mem_addr   <= pc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
// Bench for alu_sequencer: a program memory responder with configurable ack
// latency, a combinational ALU, and an instruction-level reference model.
// ALU opcodes used by the bench: 0 ADC, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR,
// others pass operand b with carry-in as carry-out.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic       mem_ack;
    logic [7:0] mem_data;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_carry;
    logic [3:0] alu_op;
    logic [7:0] alu_c;
    logic       alu_carry_out;
    logic       alu_zero;
    logic [7:0] acc;
    logic       carry_flag;
    logic       zero_flag;
    logic       busy;
    logic       halted;

    alu_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_ack      (mem_ack),
        .mem_data     (mem_data),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_carry    (alu_carry),
        .alu_op       (alu_op),
        .alu_c        (alu_c),
        .alu_carry_out(alu_carry_out),
        .alu_zero     (alu_zero),
        .acc          (acc),
        .carry_flag   (carry_flag),
        .zero_flag    (zero_flag),
        .busy         (busy),
        .halted       (halted)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] mem [0:255];
    logic [7:0] rd_log [$];
    int         ack_cyc [$];
    int         ack_delay = 1;
    bit         ack_rand  = 1'b0;
    bit         resp_en   = 1'b1;
    int         unstable  = 0;
    int         cyc       = 0;

    // Reference model state
    logic [7:0] m_acc;
    logic       m_c;
    logic       m_z;
    logic [7:0] m_last;
    int         m_reads;

    function automatic logic [8:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                             input logic [7:0] b, input logic cin);
        logic [8:0] r;
        case (op)
            4'd0:    r = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            4'd1:    r = {1'b0, a} + {1'b0, b};
            4'd2:    r = {1'b0, a} - {1'b0, b};
            4'd3:    r = {1'b0, a & b};
            4'd4:    r = {1'b0, a | b};
            4'd5:    r = {1'b0, a ^ b};
            default: r = {cin, b};
        endcase
        return r;
    endfunction

    logic [8:0] alu_res;
    assign alu_res       = alu_model(alu_op, alu_a, alu_b, alu_carry);
    assign alu_c         = alu_res[7:0];
    assign alu_carry_out = alu_res[8];
    assign alu_zero      = (alu_res[7:0] == 8'd0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: acks each request after cur_delay waiting cycles and
    // notes any change of mem_addr or premature drop of mem_rd while waiting.
    initial begin : responder
        int wcnt;
        int cur_delay;
        logic [7:0] req_addr;
        wcnt = 0;
        cur_delay = 0;
        req_addr = 8'd0;
        mem_ack = 1'b0;
        mem_data = 8'd0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!resp_en) begin
                wcnt = 0;
            end else begin
                mem_ack = 1'b0;
                if (mem_rd) begin
                    if (wcnt == 0) begin
                        req_addr  = mem_addr;
                        cur_delay = ack_rand ? int'($urandom_range(0, 3)) : ack_delay;
                    end else if (mem_addr !== req_addr) begin
                        unstable++;
                    end
                    if (wcnt >= cur_delay) begin
                        mem_ack  = 1'b1;
                        mem_data = mem[mem_addr];
                        rd_log.push_back(mem_addr);
                        ack_cyc.push_back(cyc);
                        wcnt = 0;
                    end else begin
                        wcnt++;
                    end
                end else begin
                    if (wcnt != 0) unstable++;
                    wcnt = 0;
                end
            end
        end
    end

    // Instruction-level interpretation of the program in mem, starting at 0
    // from the state already held in m_acc/m_c/m_z.
    task automatic model_run();
        logic [7:0] pc;
        logic [7:0] ir;
        logic [7:0] d;
        logic [8:0] r;
        bit done;
        int steps;
        pc = 8'd0;
        m_reads = 0;
        done = 1'b0;
        steps = 0;
        while (!done && steps < 2000) begin
            steps++;
            ir = mem[pc];
            m_last = pc;
            pc = pc + 8'd1;
            m_reads++;
            if (ir[7:4] == 4'd0 || ir[7:4] == 4'd1 || ir[7:4] == 4'd3) begin
                d = mem[pc];
                m_last = pc;
                pc = pc + 8'd1;
                m_reads++;
            end else begin
                d = 8'd0;
            end
            case (ir[7:4])
                4'd0: begin
                    r = alu_model(ir[3:0], m_acc, d, m_c);
                    m_acc = r[7:0];
                    m_c = r[8];
                    m_z = (r[7:0] == 8'd0);
                end
                4'd1: begin
                    m_acc = d;
                    m_z = (d == 8'd0);
                end
                4'd2: done = 1'b1;
                4'd3: if (m_z) pc = d;
                4'd4: m_c = 1'b0;
                default: ;
            endcase
        end
    endtask

    task automatic load_prog(input logic [7:0] b0, b1, b2, b3, b4, b5, b6);
        for (int i = 0; i < 256; i++) mem[i] = 8'h20;
        mem[0] = b0; mem[1] = b1; mem[2] = b2; mem[3] = b3;
        mem[4] = b4; mem[5] = b5; mem[6] = b6;
    endtask

    task automatic clear_log();
        rd_log.delete();
        ack_cyc.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        clear_log();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_acks(input int n, input int budget, output bit ok);
        int k;
        k = 0;
        ok = 1'b1;
        while (rd_log.size() < n) begin
            @(posedge clk);
            k++;
            if (k > budget) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_halt(input int budget, output bit ok);
        int k;
        k = 0;
        ok = 1'b1;
        while (halted !== 1'b1) begin
            @(negedge clk);
            k++;
            if (k > budget) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        #3 reset = 1'b1;
        #1;
        n_vec++; if (acc !== 8'h00) begin n_err++; $display("FAIL reset_acc: got %h expected 00", acc); end
        n_vec++; if ({carry_flag, zero_flag} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b expected 00", {carry_flag, zero_flag}); end
        n_vec++; if ({mem_rd, busy, halted} !== 3'b000) begin n_err++; $display("FAIL reset_ctrl: got %b expected 000", {mem_rd, busy, halted}); end
        n_vec++; if (mem_addr !== 8'h00) begin n_err++; $display("FAIL reset_addr: got %h expected 00", mem_addr); end
        n_vec++; if ({alu_a, alu_b, alu_op, alu_carry} !== 21'd0) begin n_err++; $display("FAIL reset_alu: got %h expected 0", {alu_a, alu_b, alu_op, alu_carry}); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        clear_log();
    endtask

    task automatic test_prog_basic();
        bit ok;
        load_prog(8'h10, 8'hF0, 8'h01, 8'h20, 8'h00, 8'h00, 8'h20);
        ack_delay = 1;
        ack_rand = 1'b0;
        pulse_start();
        wait_acks(4, 200, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL basic_ack4: got timeout expected 4 acks"); end
        @(posedge clk);
        #1;
        n_vec++; if (acc !== 8'h10) begin n_err++; $display("FAIL basic_mid_acc: got %h expected 10", acc); end
        n_vec++; if (carry_flag !== 1'b1) begin n_err++; $display("FAIL basic_mid_carry: got %b expected 1", carry_flag); end
        wait_halt(500, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL basic_halt: got timeout expected halted"); end
        n_vec++; if ({acc, carry_flag, zero_flag} !== {8'h11, 2'b00}) begin n_err++; $display("FAIL basic_final: got acc=%h c=%b z=%b expected acc=11 c=0 z=0", acc, carry_flag, zero_flag); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL basic_busy: got %b expected 0", busy); end
    endtask

    task automatic test_jz_loop();
        bit ok;
        do_reset();
        load_prog(8'h10, 8'hFF, 8'h01, 8'h01, 8'h30, 8'h00, 8'h20);
        pulse_start();
        wait_acks(6, 300, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL jz_ack6: got timeout expected 6 acks"); end
        #1;
        n_vec++; if ({acc, carry_flag, zero_flag} !== {8'h00, 2'b11}) begin n_err++; $display("FAIL jz_state: got acc=%h c=%b z=%b expected acc=00 c=1 z=1", acc, carry_flag, zero_flag); end
        n_vec++; if (mem_addr !== 8'h00) begin n_err++; $display("FAIL jz_addr: got %h expected 00", mem_addr); end
        wait_acks(7, 300, ok);
        n_vec++; if (!ok || rd_log[6] !== 8'h00) begin n_err++; $display("FAIL jz_next_read: got %h expected 00", ok ? rd_log[6] : 8'hxx); end
    endtask

    task automatic test_ack_wait();
        bit ok;
        do_reset();
        load_prog(8'h10, 8'hF0, 8'h01, 8'h20, 8'h00, 8'h00, 8'h20);
        ack_delay = 3;
        unstable = 0;
        pulse_start();
        wait_halt(1000, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL wait_halt: got timeout expected halted"); end
        n_vec++; if (unstable !== 0) begin n_err++; $display("FAIL wait_stable: got %0d unstable cycles expected 0", unstable); end
        n_vec++; if ({acc, carry_flag, zero_flag} !== {8'h11, 2'b00}) begin n_err++; $display("FAIL wait_final: got acc=%h c=%b z=%b expected acc=11 c=0 z=0", acc, carry_flag, zero_flag); end
        n_vec++; if (rd_log.size() !== 7) begin n_err++; $display("FAIL wait_reads: got %0d expected 7", rd_log.size()); end
        ack_delay = 1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit hit;
        do_reset();
        load_prog(8'h10, 8'hF0, 8'h01, 8'h20, 8'h00, 8'h00, 8'h20);
        ack_delay = 3;
        pulse_start();
        hit = 1'b0;
        for (int k = 0; k < 300 && !hit; k++) begin
            @(negedge clk);
            #1;
            if (rd_log.size() == 3 && mem_rd === 1'b1 && mem_addr === 8'h03) hit = 1'b1;
        end
        n_vec++; if (!hit) begin n_err++; $display("FAIL rmid_reach: got timeout expected operand wait at 03"); end
        reset = 1'b1;
        #1;
        n_vec++; if ({acc, carry_flag, zero_flag} !== 10'd0) begin n_err++; $display("FAIL rmid_state: got acc=%h c=%b z=%b expected all 0", acc, carry_flag, zero_flag); end
        n_vec++; if ({mem_rd, busy} !== 2'b00) begin n_err++; $display("FAIL rmid_ctrl: got rd=%b busy=%b expected 0 0", mem_rd, busy); end
        resp_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        mem_ack = 1'b1;
        mem_data = 8'hAA;
        @(negedge clk);
        mem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_vec++; if ({acc, busy, mem_rd, halted} !== 11'd0) begin n_err++; $display("FAIL rmid_late_ack: got acc=%h busy=%b rd=%b halted=%b expected all 0", acc, busy, mem_rd, halted); end
        ack_delay = 1;
        resp_en = 1'b1;
        clear_log();
        pulse_start();
        wait_halt(500, ok);
        n_vec++; if (!ok || acc !== 8'h11) begin n_err++; $display("FAIL rmid_rerun: got acc=%h expected 11", acc); end
        n_vec++; if (rd_log.size() == 0 || rd_log[0] !== 8'h00) begin n_err++; $display("FAIL rmid_first_addr: got %h expected 00", rd_log.size() ? rd_log[0] : 8'hxx); end
    endtask

    task automatic test_start_busy();
        bit ok;
        int bad;
        do_reset();
        load_prog(8'h10, 8'hFF, 8'h01, 8'h01, 8'h20, 8'h20, 8'h20);
        pulse_start();
        wait_halt(500, ok);
        n_vec++; if (!ok || carry_flag !== 1'b1) begin n_err++; $display("FAIL sb_setup_carry: got %b expected 1", carry_flag); end
        load_prog(8'h10, 8'h05, 8'h40, 8'hF7, 8'h22, 8'h20, 8'h20);
        m_acc = 8'h00; m_c = 1'b1; m_z = 1'b1;
        model_run();
        clear_log();
        pulse_start();
        wait_acks(2, 200, ok);
        pulse_start();
        wait_halt(500, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL sb_halt: got timeout expected halted"); end
        bad = 0;
        if (rd_log.size() != 5) bad++;
        else for (int i = 0; i < 5; i++) if (rd_log[i] !== 8'(i)) bad++;
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL sb_reads: got %0d reads (%0d bad) expected 0..4", rd_log.size(), bad); end
        n_vec++; if ({acc, carry_flag, zero_flag} !== {m_acc, m_c, m_z}) begin n_err++; $display("FAIL sb_state: got acc=%h c=%b z=%b expected acc=%h c=%b z=%b", acc, carry_flag, zero_flag, m_acc, m_c, m_z); end
        n_vec++; if (carry_flag !== 1'b0) begin n_err++; $display("FAIL sb_clc: got %b expected 0", carry_flag); end
        n_vec++; if ({halted, mem_addr} !== {1'b1, 8'h04}) begin n_err++; $display("FAIL sb_halt_addr: got halted=%b addr=%h expected 1 04", halted, mem_addr); end
    endtask

    task automatic test_pc_wrap();
        bit ok;
        int bad;
        do_reset();
        for (int i = 0; i < 256; i++) mem[i] = 8'h50;
        ack_delay = 1;
        pulse_start();
        wait_acks(300, 3000, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL wrap_acks: got timeout expected 300 acks"); end
        bad = 0;
        if (ok) for (int i = 0; i < 300; i++) if (rd_log[i] !== 8'(i % 256)) bad++;
        n_vec++; if (!ok || bad !== 0) begin n_err++; $display("FAIL wrap_seq: got %0d bad addresses expected 0", bad); end
        n_vec++; if (!ok || rd_log[256] !== 8'h00) begin n_err++; $display("FAIL wrap_zero: got %h expected 00", ok ? rd_log[256] : 8'hxx); end
        n_vec++; if (!ok || (ack_cyc[256] - ack_cyc[255]) !== (ack_cyc[2] - ack_cyc[1])) begin n_err++; $display("FAIL wrap_stall: got interval %0d expected %0d", ok ? ack_cyc[256] - ack_cyc[255] : -1, ok ? ack_cyc[2] - ack_cyc[1] : -1); end
    endtask

    task automatic gen_random_prog();
        int a;
        int k;
        logic [7:0] d;
        for (int i = 0; i < 256; i++) mem[i] = 8'h20;
        a = 0;
        while (a < 40) begin
            k = $urandom_range(0, 9);
            d = 8'($urandom);
            // Operand bytes never decode as JZ, so a jump landing on one
            // cannot create a backward branch.
            if (d[7:4] == 4'h3) d[7:4] = 4'h9;
            case (k)
                0, 1, 2, 3: begin
                    mem[a] = {4'h0, 4'($urandom_range(0, 7))};
                    mem[a + 1] = d;
                    a += 2;
                end
                4: begin
                    mem[a] = {4'h1, 4'($urandom)};
                    mem[a + 1] = d;
                    a += 2;
                end
                5: begin
                    mem[a] = {4'h3, 4'($urandom)};
                    mem[a + 1] = 8'($urandom_range(a + 2, 47));
                    a += 2;
                end
                6: begin
                    mem[a] = {4'h4, 4'($urandom)};
                    a += 1;
                end
                default: begin
                    mem[a] = {4'($urandom_range(5, 15)), 4'($urandom)};
                    a += 1;
                end
            endcase
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int p = 0; p < 10; p++) begin
            do_reset();
            gen_random_prog();
            ack_rand = p[0];
            ack_delay = $urandom_range(0, 3);
            m_acc = 8'h00; m_c = 1'b0; m_z = 1'b0;
            model_run();
            pulse_start();
            wait_halt(5000, ok);
            n_vec++; if (!ok) begin n_err++; $display("FAIL rand%0d_halt: got timeout expected halted", p); end
            n_vec++; if ({acc, carry_flag, zero_flag} !== {m_acc, m_c, m_z}) begin n_err++; $display("FAIL rand%0d_state: got acc=%h c=%b z=%b expected acc=%h c=%b z=%b", p, acc, carry_flag, zero_flag, m_acc, m_c, m_z); end
            n_vec++; if (mem_addr !== m_last) begin n_err++; $display("FAIL rand%0d_last_addr: got %h expected %h", p, mem_addr, m_last); end
            n_vec++; if (rd_log.size() !== m_reads) begin n_err++; $display("FAIL rand%0d_reads: got %0d expected %0d", p, rd_log.size(), m_reads); end
        end
        ack_rand = 1'b0;
        ack_delay = 1;
    endtask

    initial begin
        test_reset();
        test_prog_basic();
        test_jz_loop();
        test_ack_wait();
        test_reset_mid();
        test_start_busy();
        test_pc_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
